booth_mult_seq: RTL and testbench
=================================

# booth_mult_seq

Parametrised, multi-cycle radix-2 Booth multiplier with a start/busy/done handshake. It processes one multiplier bit per clock and supports signed or unsigned operands, selected per operation. It is the sequential, width-generic successor to the team's 4-bit combinational Booth multiplier, and is intended for datapaths that trade latency for area.

## Interface
- `WIDTH`, default 8: operand width in bits; legal values ≥ 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a multiply; accepted only when `busy`=0.
- `is_signed`  in  1: 1 = two's-complement operands; 0 = unsigned. Sampled with `start`.
- `multiplicand`  in  WIDTH: M operand, sampled with `start`.
- `multiplier`  in  WIDTH: Q operand, sampled with `start`.
- `busy`  out  1: high while iterating.
- `done`  out  1: one-cycle pulse; `product` is valid from this cycle.
- `product`  out  2*WIDTH: result, held until the next accepted `start` completes.

## Operation
- Internal working width is N = WIDTH+1. Operands are extended to N bits: sign-extended when `is_signed`=1, zero-extended when 0.
- Registers:
  - A, N bits, the accumulator.
  - Qr, N bits, the multiplier.
  - q_1, the previous LSB.
  - M, N bits.
  - cnt, counting remaining iterations.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE, `start`=1: load A=0, Qr=ext(multiplier), q_1=0, M=ext(multiplicand), cnt=N. Go to RUN.
  - IDLE or DONE, `start`=0: go to IDLE.
  - RUN, each cycle:
    - {Qr[0],q_1}=10: A=A−M. 01: A=A+M. 00/11: no add. All arithmetic is N-bit modulo.
    - Then arithmetic right shift {A,Qr,q_1} by 1, with A's MSB replicated.
    - Decrement cnt. Go to DONE when cnt reaches 0.
  - On entry to DONE: `product` ← low 2*WIDTH bits of {A,Qr}.
- Signed and unsigned modes both run N iterations, so latency is uniform. The result is exact for all operand values: −2^(W−1)·−2^(W−1) fits in 2W bits signed, and (2^W−1)² fits in 2W bits unsigned.
- `start` while `busy`=1 is ignored; inputs need not be held after acceptance.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, state=IDLE, all internal registers 0.
- `start` sampled high at edge t0 (state IDLE or DONE):
  - `busy`=1 in cycles t0+1 … t0+N.
  - `done`=1 and new `product` in cycle t0+N+1.
  - `busy`=0 during the `done` cycle.
- Back-to-back: `start` in the `done` cycle is accepted. Throughput is one result per N+1 cycles.
- `rst` asserted mid-operation: the next edge returns to reset values. The partial result is discarded and no `done` is issued.
- `rst` and `start` in the same cycle: reset wins.
- `done` never asserts on two consecutive cycles.

## Configuration
- `BOOTH_EARLY_TERM_EN` defined: at each RUN cycle, if the unconsumed bits Qr[cnt−1:0] and q_1 are all 0 or all 1, no further add/sub can occur.
  - In that case, apply an arithmetic right shift of {A,Qr} by cnt in that single cycle and go to DONE.
  - Latency becomes data-dependent, from 1 to N `busy` cycles. `product` value is identical to the non-early-termination result.
- Not defined: fixed N-cycle iteration. No variable shifter is built.

## Test plan
- WIDTH=8, signed, M=−7 (8'hF9), Q=3 → `done` at t0+10, `product`=16'hFFEB (−21).
- Signed corner cases:
  - M=Q=8'h80 (−128·−128) → `product`=16'h4000.
  - M=8'h80, Q=8'h7F → 16'hC080.
- Unsigned:
  - M=Q=8'hFF → `product`=16'hFE01.
  - M=8'h80, Q=8'h02 → 16'h0100.
- Back-to-back: second `start` in the `done` cycle (5·6 signed, then unsigned 200·3) → `done` pulses 10 cycles apart, with `product`=16'h001E then 16'h0258.
- `rst` pulsed at t0+4 of a running multiply → outputs 0 next cycle; no `done`; `product` stays 0; a new `start` then completes normally.
- With `BOOTH_EARLY_TERM_EN`:
  - Q=0 → `busy` 1 cycle, `product`=0.
  - Signed Q=8'hFF, M=5 → `product`=16'hFFFB, `busy` ≤ 2 cycles.
  - Random 1000 operand/mode sweep → matches the non-early build bit-exactly.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake bundle for the sequential Booth multiplier.
// master = requester driving operands, slave = multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Multi-cycle radix-2 Booth multiplier, signed or unsigned per operation.
// Optional BOOTH_EARLY_TERM_EN: finish early once no further add/sub can occur.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one Booth step per cycle, busy high
// S_DONE | one-cycle done pulse, product freshly valid
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  booth_mult_seq_if.slave    bus
);
  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [N-1:0]         acc, qr, m_reg, acc_sum;
  logic                 q_1;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_q;
  logic [N-1:0]         m_ext, q_ext;
  logic [2*N:0]         step;
  logic [2*N-1:0]       aq_nxt;
  logic                 q1_nxt;
  logic                 run_fin;

  // The extra bit lets unsigned operands run through the signed datapath.
  assign m_ext = bus.is_signed ? {bus.multiplicand[WIDTH-1], bus.multiplicand}
                               : {1'b0, bus.multiplicand};
  assign q_ext = bus.is_signed ? {bus.multiplier[WIDTH-1], bus.multiplier}
                               : {1'b0, bus.multiplier};

  always_comb begin
    acc_sum = acc;
    case ({qr[0], q_1})
      2'b10:   acc_sum = acc - m_reg;
      2'b01:   acc_sum = acc + m_reg;
      default: acc_sum = acc;
    endcase
  end

  // {A,Qr,q_1} shifted right by one with A's sign replicated.
  assign step = {acc_sum[N-1], acc_sum, qr};

`ifdef BOOTH_EARLY_TERM_EN
  logic [N-1:0]          one_n, mask;
  logic                  early;
  logic signed [2*N-1:0] aq_s;
  logic [2*N-1:0]        jump;

  assign one_n = {{(N-1){1'b0}}, 1'b1};
  assign mask  = (one_n << cnt) - one_n;
  assign early = (((qr & mask) == '0) && !q_1) || (((qr & mask) == mask) && q_1);
  assign aq_s  = {acc, qr};
  assign jump  = aq_s >>> cnt;

  always_comb begin
    if (early) begin
      aq_nxt  = jump;
      q1_nxt  = q_1;
      run_fin = 1'b1;
    end else begin
      aq_nxt  = step[2*N:1];
      q1_nxt  = step[0];
      run_fin = (cnt == CW'(1));
    end
  end
`else
  always_comb begin
    aq_nxt  = step[2*N:1];
    q1_nxt  = step[0];
    run_fin = (cnt == CW'(1));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = bus.start ? S_RUN : S_IDLE;
      S_RUN:          state_nxt = run_fin ? S_DONE : S_RUN;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      S_RUN:   bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      qr        <= '0;
      q_1       <= 1'b0;
      m_reg     <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (state == S_RUN) begin
      {acc, qr} <= aq_nxt;
      q_1       <= q1_nxt;
      cnt       <= cnt - CW'(1);
      if (run_fin) product_q <= aq_nxt[2*WIDTH-1:0];
    end else if (bus.start) begin
      acc   <= '0;
      qr    <= q_ext;
      q_1   <= 1'b0;
      m_reg <= m_ext;
      cnt   <= CW'(N);
    end
  end

  assign bus.product = product_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks of booth_mult_seq at WIDTH=8; latency
// expectations follow BOOTH_EARLY_TERM_EN when defined.
module tb_booth_mult_seq;
  localparam int W = 8;
  localparam int N = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  booth_mult_seq_if #(.WIDTH(W)) bus ();
  booth_mult_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic sgn, input logic [W-1:0] m, input logic [W-1:0] q);
    bus.start        = 1'b1;
    bus.is_signed    = sgn;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = 8'h5A;
    bus.multiplier   = 8'hA5;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    else          chk("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic mult(input string tag, input logic sgn, input logic [W-1:0] m,
                      input logic [W-1:0] q, input logic [15:0] exp);
    int lat, nb;
    launch(sgn, m, q);
    wait_done(lat, nb);
    chk(tag, 32'(bus.product), 32'(exp));
`ifdef BOOTH_EARLY_TERM_EN
    chk({tag, "_busy_range"}, 32'((nb >= 1) && (nb <= N)), 32'd1);
`else
    chk({tag, "_lat"}, 32'(lat), 32'(N + 1));
    chk({tag, "_nbusy"}, 32'(nb), 32'(N));
`endif
  endtask

  initial begin
    int lat, nb, ndone;
    logic [W-1:0] rm, rq;
    logic         rs;
    int           a, b;

    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);

    // -7 * 3 with exact latency and single-cycle done pulse
    launch(1'b1, 8'hF9, 8'h03);
    wait_done(lat, nb);
    chk("s_m7x3", 32'(bus.product), 32'h0000_FFEB);
`ifndef BOOTH_EARLY_TERM_EN
    chk("s_m7x3_lat", 32'(lat), 32'd10);
`endif
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("product_held", 32'(bus.product), 32'h0000_FFEB);

    mult("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
    mult("s_80x7f", 1'b1, 8'h80, 8'h7F, 16'hC080);
    mult("u_ffxff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    mult("u_80x02", 1'b0, 8'h80, 8'h02, 16'h0100);
    mult("s_ffxff", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    mult("u_0x0",   1'b0, 8'h00, 8'h00, 16'h0000);

    // back-to-back: second start driven during the done cycle
    launch(1'b1, 8'd5, 8'd6);
    wait_done(lat, nb);
    chk("b2b_first", 32'(bus.product), 32'h0000_001E);
    launch(1'b0, 8'd200, 8'd3);
    wait_done(lat, nb);
    chk("b2b_second", 32'(bus.product), 32'h0000_0258);
`ifndef BOOTH_EARLY_TERM_EN
    chk("b2b_spacing", 32'(lat), 32'd10);
`endif

    // start ignored while busy
    launch(1'b0, 8'd10, 8'd10);
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 8'd3;
    bus.multiplier = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, nb);
    chk("busy_ignore", 32'(bus.product), 32'h0000_0064);
    @(negedge clk);
    chk("busy_ignore_idle", 32'(bus.busy), 32'd0);

    // reset at t0+4 discards the operation
    launch(1'b1, 8'd5, 8'd6);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    chk("midrst_product_hold", 32'(bus.product), 32'd0);
    mult("post_rst", 1'b1, 8'hF9, 8'h03, 16'hFFEB);

    // reset and start in the same cycle: reset wins
    @(negedge clk);
    rst = 1'b1;
    launch(1'b0, 8'd7, 8'd7);
    chk("rst_start_busy", 32'(bus.busy), 32'd0);
    chk("rst_start_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", 32'(bus.busy), 32'd0);

    // early-termination vectors (latency differs by build)
    launch(1'b1, 8'd5, 8'h00);
    wait_done(lat, nb);
    chk("q0_product", 32'(bus.product), 32'd0);
`ifdef BOOTH_EARLY_TERM_EN
    chk("q0_busy", 32'(nb), 32'd1);
`else
    chk("q0_busy", 32'(nb), 32'(N));
`endif
    launch(1'b1, 8'd5, 8'hFF);
    wait_done(lat, nb);
    chk("qff_product", 32'(bus.product), 32'h0000_FFFB);
`ifdef BOOTH_EARLY_TERM_EN
    chk("qff_busy_le2", 32'(nb <= 2), 32'd1);
`else
    chk("qff_busy", 32'(nb), 32'(N));
`endif

    // random sweep against an integer reference product
    for (int k = 0; k < 1000; k++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      rs = 1'($urandom);
      a = rs ? int'($signed(rm)) : int'(rm);
      b = rs ? int'($signed(rq)) : int'(rq);
      mult("rand", rs, rm, rq, 16'(a * b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
